unidade_busca: RTL and testbench
================================

UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries.
REQ-003 Parameter HALT_OPCODE, default 8'h00, instruction that stops fetch.
REQ-004 Clock  input  1  sole clock, all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 MemEndereco  output  8  instruction-memory read address (= FetchPC).
REQ-007 MemLer  output  1  read issued this cycle.
REQ-008 MemInstrucao  input  8  read data, valid in the cycle after an issued read.
REQ-009 Desvio  input  1  redirect request from the core (taken jump/branch).
REQ-010 AlvoDesvio  input  8  redirect target address.
REQ-011 Parar  input  1  core stall; instruction not consumed while 1.
REQ-012 Instrucao  output  8  instruction at FIFO head.
REQ-013 InstrucaoValida  output  1  head entry valid.
REQ-014 PCInstrucao  output  8  address of the instruction at FIFO head.
REQ-015 Halt  output  1  sticky; HALT_OPCODE consumed.

Function
REQ-016 Consume (pop) SHALL occur in a cycle where InstrucaoValida=1 and Parar=0 and Desvio=0.
REQ-017 MemLer SHALL be 1 when Halt=0, Desvio=0 and (count + inflight - pop) < DEPTH; inflight is 0 or 1.
REQ-018 On an issued read, FetchPC SHALL increment by 1 modulo 256 (8'hFF wraps to 8'h00).
REQ-019 Read data SHALL be written to the FIFO tail with its fetch address at the end of the cycle after issue, unless squashed.
REQ-020 Latency: an empty buffer SHALL present a fetched instruction 2 cycles after MemLer=1 (no bypass).
REQ-021 With Parar=0, no Desvio and no halt, throughput SHALL be one instruction per cycle.
REQ-022 Instrucao/PCInstrucao SHALL be 8'h00 when InstrucaoValida=0.
REQ-023 Desvio=1 SHALL, at the clock edge, empty the FIFO, squash any in-flight read, set FetchPC to AlvoDesvio; MemLer=0 that cycle; first read of AlvoDesvio issues the next cycle.
REQ-024 Desvio SHALL take priority over simultaneous capture and consume.
REQ-025 Consuming an instruction equal to HALT_OPCODE SHALL set Halt at that edge; thereafter MemLer=0, InstrucaoValida=0, Desvio ignored.
REQ-026 Halt SHALL clear only on Reset.
REQ-027 Simultaneous capture and pop on a full buffer SHALL keep count unchanged and lose no data.
REQ-028 Parar SHALL hold the head entry stable; no overflow may occur (guaranteed by REQ-017).

Reset
REQ-029 While Reset=0: FetchPC=8'h00, FIFO empty, inflight=0, MemLer=0, InstrucaoValida=0, Instrucao=8'h00, PCInstrucao=8'h00, Halt=0.
REQ-030 MemEndereco SHALL be 8'h00 during reset; first read (address 0) SHALL issue in the first cycle after Reset rises.
REQ-031 Reset asserted mid-operation SHALL discard buffer and in-flight data; data returning after reset release SHALL not be captured.

Structure
REQ-032 Shared package SHALL hold DEPTH default, HALT_OPCODE, address width 8, instruction width 8.
REQ-033 One sub-module fila_instrucao SHALL implement the DEPTH-entry FIFO of {instruction, pc} with push, pop, flush, count.
REQ-034 Fetch control (FetchPC, inflight, squash, Halt) SHALL live in unidade_busca.

Verification
REQ-035 Reset release, memory 0..3 = 8'h11,8'h22,8'h33,8'h00, Parar=0 -> MemLer cycles 0,1,2,3; InstrucaoValida from cycle 2; PCInstrucao 0,1,2,3; Halt=1 after consuming addr 3; MemLer=0 afterward.
REQ-036 Parar=1 for 5 cycles after first valid -> buffer fills to 2, MemLer=0, Instrucao stable at 8'h11; on Parar=0 sequence resumes without loss or duplication.
REQ-037 Desvio=1, AlvoDesvio=8'h40 while a read is in flight -> in-flight data dropped, InstrucaoValida=0 next cycle, next MemEndereco=8'h40, next valid PCInstrucao=8'h40.
REQ-038 Desvio to 8'hFE, no halt opcodes -> PCInstrucao sequence 8'hFE, 8'hFF, 8'h00, 8'h01.
REQ-039 Reset=0 asserted asynchronously mid-stream with full buffer -> all outputs at reset values immediately; after release, fetch restarts at 8'h00.
REQ-040 Desvio in same cycle as consuming HALT_OPCODE head -> Desvio wins, no Halt, fetch from target.

Source files
------------

// File: rtl/unidade_busca_pkg.sv
// Shared widths, parameter defaults, FIFO entry type and small helpers for the fetch unit.
package unidade_busca_pkg;

  localparam int ADDR_W       = 8;
  localparam int INSTR_W      = 8;
  localparam int DEPTH_PADRAO = 2;
  localparam logic [INSTR_W-1:0] HALT_OPCODE_PADRAO = 8'h00;

  // One prefetch buffer entry: the instruction and the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entrada_t;

  // Sequential fetch address; wraps naturally from 8'hFF to 8'h00.
  function automatic logic [ADDR_W-1:0] proximo_pc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fila_instrucao.sv
// Circular prefetch buffer of {instruction, pc} entries with push, pop, flush and occupancy.
module fila_instrucao
  import unidade_busca_pkg::*;
#(
  parameter int DEPTH = DEPTH_PADRAO,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entrada_t         entrada,
  output entrada_t         cabeca,
  output logic [CNT_W-1:0] contagem
);

  entrada_t         mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             cheia_s;
  logic             vazia_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointer step with wrap at DEPTH, so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] avanca(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Guard against overflow/underflow even if the controller misbehaves; a push into a
  // full buffer is only legal when the head leaves in the same cycle.
  always_comb begin
    cheia_s   = (count_r == CNT_W'(DEPTH));
    vazia_s   = (count_r == {CNT_W{1'b0}});
    push_ok_s = push & (~cheia_s | (pop & ~vazia_s));
    pop_ok_s  = pop & ~vazia_s;
  end

  // Read/write pointers and occupancy; flush empties the buffer and wins over push/pop.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= avanca(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= avanca(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so stale data never reaches the head.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= entrada;
    end
  end

  assign cabeca   = mem_r[rd_ptr_r];
  assign contagem = count_r;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: issues sequential reads, buffers returned instructions and
// hands them to the core, with redirect (Desvio), stall (Parar) and sticky halt.
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter int                 DEPTH       = DEPTH_PADRAO,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_PADRAO
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  MemEndereco,
  output logic               MemLer,
  input  logic [INSTR_W-1:0] MemInstrucao,
  input  logic               Desvio,
  input  logic [ADDR_W-1:0]  AlvoDesvio,
  input  logic               Parar,
  output logic [INSTR_W-1:0] Instrucao,
  output logic               InstrucaoValida,
  output logic [ADDR_W-1:0]  PCInstrucao,
  output logic               Halt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic              inflight_r;
  logic              halt_r;

  entrada_t          cabeca_s;
  entrada_t          captura_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W:0]    ocupacao_s;
  logic              desvio_s;
  logic              valida_s;
  logic              pop_s;
  logic              push_s;
  logic              ler_s;
  logic              halt_set_s;

  // Per-cycle decode. A redirect is ignored once halted and overrides capture and consume.
  // Reads are throttled so that buffered + in-flight entries never exceed DEPTH, counting
  // the slot freed by a consume in the same cycle; reset also blocks issue immediately.
  always_comb begin
    desvio_s   = Desvio & ~halt_r;
    valida_s   = (count_s != {CNT_W{1'b0}}) & ~halt_r;
    pop_s      = valida_s & ~Parar & ~desvio_s;
    push_s     = inflight_r & ~desvio_s & ~halt_r;
    ocupacao_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
    if (halt_r || desvio_s || !Reset) begin
      ler_s = 1'b0;
    end else if (ocupacao_s < (CNT_W + 1)'(DEPTH)) begin
      ler_s = 1'b1;
    end else begin
      ler_s = 1'b0;
    end
    halt_set_s      = pop_s & (cabeca_s.instr == HALT_OPCODE);
    captura_s.instr = MemInstrucao;
    captura_s.pc    = inflight_pc_r;
  end

  // Fetch address, in-flight read tracking (squashed by a redirect) and sticky halt.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fetch_pc_r    <= {ADDR_W{1'b0}};
      inflight_pc_r <= {ADDR_W{1'b0}};
      inflight_r    <= 1'b0;
      halt_r        <= 1'b0;
    end else begin
      if (desvio_s) begin
        fetch_pc_r <= AlvoDesvio;
        inflight_r <= 1'b0;
      end else if (ler_s) begin
        fetch_pc_r    <= proximo_pc(fetch_pc_r);
        inflight_pc_r <= fetch_pc_r;
        inflight_r    <= 1'b1;
      end else begin
        inflight_r <= 1'b0;
      end
      if (halt_set_s) begin
        halt_r <= 1'b1;
      end
    end
  end

  fila_instrucao #(
    .DEPTH (DEPTH)
  ) u_fila (
    .Clock    (Clock),
    .Reset    (Reset),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (desvio_s),
    .entrada  (captura_s),
    .cabeca   (cabeca_s),
    .contagem (count_s)
  );

  assign MemEndereco     = fetch_pc_r;
  assign MemLer          = ler_s;
  assign InstrucaoValida = valida_s;
  assign Instrucao       = valida_s ? cabeca_s.instr : {INSTR_W{1'b0}};
  assign PCInstrucao     = valida_s ? cabeca_s.pc : {ADDR_W{1'b0}};
  assign Halt            = halt_r;

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: memory model, consume scoreboard, scenario tasks.
module tb_unidade_busca;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] MemEndereco;
  logic       MemLer;
  logic [7:0] MemInstrucao = 8'h00;
  logic       Desvio = 1'b0;
  logic [7:0] AlvoDesvio = 8'h00;
  logic       Parar = 1'b0;
  logic [7:0] Instrucao;
  logic       InstrucaoValida;
  logic [7:0] PCInstrucao;
  logic       Halt;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] esperado;
  int          n_checks = 0;
  int          n_errors = 0;

  unidade_busca #(.DEPTH(2), .HALT_OPCODE(8'h00)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .MemEndereco     (MemEndereco),
    .MemLer          (MemLer),
    .MemInstrucao    (MemInstrucao),
    .Desvio          (Desvio),
    .AlvoDesvio      (AlvoDesvio),
    .Parar           (Parar),
    .Instrucao       (Instrucao),
    .InstrucaoValida (InstrucaoValida),
    .PCInstrucao     (PCInstrucao),
    .Halt            (Halt)
  );

  // Clock generation.
  always #5 Clock = ~Clock;

  // Synchronous instruction memory: data for an issued read appears the next cycle.
  always @(posedge Clock) begin
    MemInstrucao <= MemLer ? mem[MemEndereco] : 8'h00;
  end

  // Scoreboard: every consumed instruction must match the next expected {pc, instr}.
  always @(negedge Clock) begin
    #3;
    if (Reset && InstrucaoValida && !Parar && !Desvio) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL consumo_extra: got pc %h instr %h, expected nothing", PCInstrucao, Instrucao);
      end else begin
        esperado = exp_q.pop_front();
        if ({PCInstrucao, Instrucao} !== esperado) begin
          n_errors++;
          $display("FAIL consumo: got pc %h instr %h, expected pc %h instr %h",
                   PCInstrucao, Instrucao, esperado[15:8], esperado[7:0]);
        end
      end
    end
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1);
  end

  task automatic espera(input logic [7:0] pc);
    exp_q.push_back({pc, mem[pc]});
  endtask

  // Resets the DUT and returns at the negedge where Reset is released (cycle 0).
  task automatic aplica_reset;
    @(negedge Clock);
    Reset = 1'b0; Parar = 1'b0; Desvio = 1'b0; AlvoDesvio = 8'h00;
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset;
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    n_checks++;
    if ({MemLer, InstrucaoValida, Halt} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 000", {MemLer, InstrucaoValida, Halt});
    end
    n_checks++;
    if ({MemEndereco, Instrucao, PCInstrucao} !== 24'h000000) begin
      n_errors++; $display("FAIL reset_dados: got %h expected 000000", {MemEndereco, Instrucao, PCInstrucao});
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    n_checks++;
    if (MemLer !== 1'b1 || MemEndereco !== 8'h00) begin
      n_errors++; $display("FAIL reset_primeira_leitura: got ler %b end %h expected ler 1 end 00", MemLer, MemEndereco);
    end
  endtask

  task automatic test_basico;
    aplica_reset();
    for (int p = 0; p < 4; p++) espera(8'(p));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge Clock);
      #1;
      if (k < 4) begin
        n_checks++;
        if (MemLer !== 1'b1 || MemEndereco !== 8'(k)) begin
          n_errors++; $display("FAIL basico_leitura: cycle %0d got ler %b end %h expected ler 1 end %h", k, MemLer, MemEndereco, 8'(k));
        end
      end
      if (k == 1) begin
        n_checks++;
        if (InstrucaoValida !== 1'b0) begin
          n_errors++; $display("FAIL basico_latencia_cedo: got valida %b expected 0", InstrucaoValida);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (InstrucaoValida !== 1'b1 || PCInstrucao !== 8'h00 || Instrucao !== 8'h11) begin
          n_errors++; $display("FAIL basico_latencia: got valida %b pc %h instr %h expected 1 00 11", InstrucaoValida, PCInstrucao, Instrucao);
        end
      end
    end
    n_checks++;
    if ({Halt, MemLer, InstrucaoValida} !== 3'b100 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL basico_halt: got halt/ler/valida %b pendentes %0d expected 100 and 0", {Halt, MemLer, InstrucaoValida}, exp_q.size());
    end
    @(negedge Clock);
    Desvio = 1'b1; AlvoDesvio = 8'h40;
    #1;
    n_checks++;
    if (MemLer !== 1'b0) begin
      n_errors++; $display("FAIL halt_desvio_ler: got %b expected 0", MemLer);
    end
    @(negedge Clock);
    Desvio = 1'b0;
    #1;
    n_checks++;
    if (Halt !== 1'b1 || InstrucaoValida !== 1'b0 || MemEndereco === 8'h40) begin
      n_errors++; $display("FAIL halt_desvio_ignorado: got halt %b valida %b end %h expected 1 0 not 40", Halt, InstrucaoValida, MemEndereco);
    end
  endtask

  task automatic test_parar;
    aplica_reset();
    for (int p = 0; p < 4; p++) espera(8'(p));
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge Clock);
      Parar = (k >= 2 && k <= 6);
      #1;
      if (k >= 2 && k <= 6) begin
        n_checks++;
        if (InstrucaoValida !== 1'b1 || Instrucao !== 8'h11 || PCInstrucao !== 8'h00) begin
          n_errors++; $display("FAIL parar_estavel: cycle %0d got valida %b instr %h pc %h expected 1 11 00", k, InstrucaoValida, Instrucao, PCInstrucao);
        end
      end
      if (k >= 3 && k <= 6) begin
        n_checks++;
        if (MemLer !== 1'b0) begin
          n_errors++; $display("FAIL parar_cheio_ler: cycle %0d got %b expected 0", k, MemLer);
        end
      end
    end
    n_checks++;
    if (Halt !== 1'b1 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL parar_retomada: got halt %b pendentes %0d expected 1 and 0", Halt, exp_q.size());
    end
  endtask

  task automatic test_desvio;
    aplica_reset();
    for (int p = 8'h40; p < 8'h44; p++) espera(8'(p));
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge Clock);
      Desvio = (k == 1); AlvoDesvio = 8'h40; Parar = (k == 8);
      #1;
      if (k == 1) begin
        n_checks++;
        if (MemLer !== 1'b0) begin
          n_errors++; $display("FAIL desvio_ler: got %b expected 0", MemLer);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (InstrucaoValida !== 1'b0 || MemEndereco !== 8'h40 || MemLer !== 1'b1) begin
          n_errors++; $display("FAIL desvio_alvo: got valida %b end %h ler %b expected 0 40 1", InstrucaoValida, MemEndereco, MemLer);
        end
      end
      if (k == 3) begin
        n_checks++;
        if ({InstrucaoValida, Instrucao, PCInstrucao} !== 17'h00000) begin
          n_errors++; $display("FAIL desvio_descartado: got valida %b instr %h pc %h expected 0 00 00", InstrucaoValida, Instrucao, PCInstrucao);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (InstrucaoValida !== 1'b1 || PCInstrucao !== 8'h40) begin
          n_errors++; $display("FAIL desvio_primeira: got valida %b pc %h expected 1 40", InstrucaoValida, PCInstrucao);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL desvio_pendentes: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_volta;
    logic [7:0] ends [4];
    ends[0] = 8'hFE; ends[1] = 8'hFF; ends[2] = 8'h00; ends[3] = 8'h01;
    aplica_reset();
    for (int p = 0; p < 4; p++) espera(ends[p]);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge Clock);
      Desvio = (k == 1); AlvoDesvio = 8'hFE; Parar = (k == 8);
      #1;
      if (k >= 2 && k <= 5) begin
        n_checks++;
        if (MemEndereco !== ends[k-2] || MemLer !== 1'b1) begin
          n_errors++; $display("FAIL volta_endereco: cycle %0d got end %h ler %b expected %h 1", k, MemEndereco, MemLer, ends[k-2]);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL volta_pendentes: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_meio;
    aplica_reset();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge Clock);
      Parar = (k >= 2);
    end
    #1;
    n_checks++;
    if (InstrucaoValida !== 1'b1 || MemLer !== 1'b0) begin
      n_errors++; $display("FAIL reset_meio_cheio: got valida %b ler %b expected 1 0", InstrucaoValida, MemLer);
    end
    #1 Reset = 1'b0;
    #1;
    n_checks++;
    if ({MemLer, InstrucaoValida, Halt, MemEndereco, Instrucao, PCInstrucao} !== 27'h0) begin
      n_errors++; $display("FAIL reset_meio_imediato: got ler %b valida %b halt %b end %h instr %h pc %h expected all zero",
                           MemLer, InstrucaoValida, Halt, MemEndereco, Instrucao, PCInstrucao);
    end
    @(negedge Clock);
    @(negedge Clock);
    exp_q.delete();
    espera(8'h00); espera(8'h01);
    Reset = 1'b1; Parar = 1'b0;
    #1;
    n_checks++;
    if (MemLer !== 1'b1 || MemEndereco !== 8'h00 || InstrucaoValida !== 1'b0) begin
      n_errors++; $display("FAIL reset_meio_reinicio: got ler %b end %h valida %b expected 1 00 0", MemLer, MemEndereco, InstrucaoValida);
    end
    for (int k = 1; k < 5; k++) begin
      @(negedge Clock);
      Parar = (k == 4);
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL reset_meio_pendentes: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_desvio_halt;
    aplica_reset();
    espera(8'h00); espera(8'h01); espera(8'h02); espera(8'h80); espera(8'h81);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge Clock);
      Desvio = (k == 5); AlvoDesvio = 8'h80; Parar = (k == 10);
      #1;
      if (k == 5) begin
        n_checks++;
        if (InstrucaoValida !== 1'b1 || Instrucao !== 8'h00 || PCInstrucao !== 8'h03) begin
          n_errors++; $display("FAIL desvio_halt_cabeca: got valida %b instr %h pc %h expected 1 00 03", InstrucaoValida, Instrucao, PCInstrucao);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (Halt !== 1'b0 || MemEndereco !== 8'h80 || MemLer !== 1'b1) begin
          n_errors++; $display("FAIL desvio_halt_vence: got halt %b end %h ler %b expected 0 80 1", Halt, MemEndereco, MemLer);
        end
      end
    end
    n_checks++;
    if (Halt !== 1'b0 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL desvio_halt_final: got halt %b pendentes %0d expected 0 and 0", Halt, exp_q.size());
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h00;
    test_reset();
    test_basico();
    test_parar();
    test_desvio();
    test_volta();
    test_reset_meio();
    test_desvio_halt();
    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
